// File: rtl/meta_rr_arb.sv
// meta_rr_arb: round-robin merge of N_ID metadata streams into one registered stream tagged with source id.
// Optional per-source handshake counters with stat_clr_i when META_RR_ARB_STATS_EN is defined.
module meta_rr_arb #(
  parameter int DATA_BITS = 96,
  parameter int N_ID = 4,
  localparam int ID_BITS = (N_ID > 1) ? $clog2(N_ID) : 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [N_ID-1:0]                s_meta_valid_i,
  output logic [N_ID-1:0]                s_meta_ready_o,
  input  logic [N_ID-1:0][DATA_BITS-1:0] s_meta_data_i,
  output logic                           m_meta_valid_o,
  input  logic                           m_meta_ready_i,
  output logic [DATA_BITS-1:0]           m_meta_data_o,
  output logic [ID_BITS-1:0]             m_id_o
`ifdef META_RR_ARB_STATS_EN
  ,
  input  logic                           stat_clr_i,
  output logic [N_ID-1:0][31:0]          stat_cnt_o
`endif
);
  logic                 out_valid_q;
  logic [DATA_BITS-1:0] out_data_q;
  logic [ID_BITS-1:0]   out_id_q;
  logic [ID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]   g, idx;
  logic                 free, any_req, grant;
  assign free    = !out_valid_q || m_meta_ready_i;
  assign any_req = |s_meta_valid_i;
  assign grant   = aresetn && free && any_req;
  // Scan offsets high to low so the valid source nearest rr_ptr is the last one written.
  always_comb begin
    g = '0;
    idx = '0;
    for (int k = N_ID - 1; k >= 0; k--) begin
      idx = ID_BITS'((int'(rr_ptr_q) + k) % N_ID);
      if (s_meta_valid_i[idx]) g = idx;
    end
  end
  assign s_meta_ready_o = grant ? (N_ID'(1) << g) : '0;
  assign rr_ptr_d = !grant ? rr_ptr_q : (g == ID_BITS'(N_ID - 1)) ? '0 : g + 1'b1;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (free) begin
        out_valid_q <= any_req;
        if (any_req) begin
          out_data_q <= s_meta_data_i[g];
          out_id_q   <= g;
        end
      end
    end
  end
  assign m_meta_valid_o = out_valid_q;
  assign m_meta_data_o  = out_data_q;
  assign m_id_o         = out_id_q;
`ifdef META_RR_ARB_STATS_EN
  logic [N_ID-1:0][31:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_ID; i++)
      cnt_d[i] = stat_clr_i ? 32'd0 : (s_meta_valid_i[i] && s_meta_ready_o[i] && cnt_q[i] != '1) ? cnt_q[i] + 32'd1 : cnt_q[i];
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stat_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_meta_rr_arb.sv
// tb_meta_rr_arb: directed and random stimulus against a queue-free behavioural model of the arbiter.
module tb_meta_rr_arb;
  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [3:0]       sv = '0, sr;
  logic [3:0][95:0] sd = '0;
  logic             mv, mr = 1'b0;
  logic [95:0]      md;
  logic [1:0]       mid;
  int total = 0, bad = 0;
  logic        ev;
  logic [95:0] ed;
  int          eid, ptr;
  logic [3:0]  acc, nv;
`ifdef META_RR_ARB_STATS_EN
  logic             clr = 1'b0;
  logic [3:0][31:0] sc;
  longint           cnts [4];
`endif
  always #5 aclk = ~aclk;
  meta_rr_arb #(.DATA_BITS(96), .N_ID(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_meta_valid_i(sv), .s_meta_ready_o(sr), .s_meta_data_i(sd),
    .m_meta_valid_o(mv), .m_meta_ready_i(mr), .m_meta_data_o(md), .m_id_o(mid)
`ifdef META_RR_ARB_STATS_EN
    , .stat_clr_i(clr), .stat_cnt_o(sc)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    ev = 1'b0; ed = '0; eid = 0; ptr = 0; acc = '0;
`ifdef META_RR_ARB_STATS_EN
    for (int i = 0; i < 4; i++) cnts[i] = 0;
`endif
  endtask
  task automatic cycle(input logic [3:0] v, input logic r);
    int w;
    logic [3:0] er;
    @(negedge aclk);
    for (int i = 0; i < 4; i++)
      if (v[i] && (!sv[i] || acc[i])) sd[i] = {$urandom, $urandom, $urandom};
    sv = v;
    mr = r;
    #1;
    w = -1;
    for (int k = 0; k < 4; k++)
      if (w < 0 && sv[(ptr + k) % 4]) w = (ptr + k) % 4;
    er = (w >= 0 && (!ev || mr)) ? 4'(1 << w) : 4'b0;
    chk("ready", sr, er);
    acc = er;
    @(posedge aclk);
    #1;
    if (!ev || mr) begin
      ev = (w >= 0);
      if (w >= 0) begin
        ed = sd[w]; eid = w; ptr = (w + 1) % 4;
      end
    end
`ifdef META_RR_ARB_STATS_EN
    for (int i = 0; i < 4; i++)
      cnts[i] = clr ? 0 : (acc[i] && cnts[i] < 64'hFFFF_FFFF) ? cnts[i] + 1 : cnts[i];
    for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), sc[i], cnts[i]);
`endif
    chk("valid", mv, ev);
    if (ev) begin
      chk("data", md, ed);
      chk("id", mid, eid);
    end
  endtask
  task automatic do_reset();
    aresetn = 1'b0;
    sv = 4'hF;
    #1;
    chk("rst_valid", mv, 0);
    chk("rst_id", mid, 0);
    chk("rst_data", md, 0);
    chk("rst_ready", sr, 0);
`ifdef META_RR_ARB_STATS_EN
    chk("rst_cnt", sc, 0);
`endif
    sv = '0;
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask
  initial begin
    model_reset();
    #2;
    do_reset();
    cycle(4'b0100, 1'b1);
    chk("single_ptr", ptr, 3);
    cycle(4'b0000, 1'b1);
    @(negedge aclk);
    do_reset();
    repeat (8) cycle(4'b1111, 1'b1);
    cycle(4'b1010, 1'b0);
    repeat (5) cycle(4'b1010, 1'b0);
    cycle(4'b1010, 1'b1);
    cycle(4'b1010 & ~acc, 1'b1);
    cycle(4'b0000, 1'b1);
    @(negedge aclk);
    do_reset();
    cycle(4'b0100, 1'b1);
    cycle(4'b1001, 1'b1);
    chk("wrap_id3", mid, 3);
    cycle(4'b0001, 1'b1);
    chk("wrap_id0", mid, 0);
    chk("wrap_ptr", ptr, 1);
    cycle(4'b0010, 1'b0);
    #2;
    chk("pre_async_valid", mv, 1);
    do_reset();
    cycle(4'b1111, 1'b1);
    chk("post_rst_first", mid, 0);
`ifdef META_RR_ARB_STATS_EN
    @(negedge aclk);
    do_reset();
    repeat (10) cycle(4'b0010, 1'b1);
    chk("cnt1_ten", sc[1], 10);
    clr = 1'b1;
    cycle(4'b0010, 1'b1);
    clr = 1'b0;
    chk("cnt1_clr", sc[1], 0);
`endif
    repeat (400) begin
      for (int i = 0; i < 4; i++) nv[i] = (sv[i] && !acc[i]) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(nv, $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/meta_rr_arb.md
Name: meta_rr_arb

Overview:
- Round-robin arbiter that merges N_ID independent metadata request streams into one registered metadata stream.
- Sits directly upstream of the metadata register slice in the request path, for example merging per-vFPGA request queues before the shared slice and host/card DMA issue logic.
- Tags each output beat with the index of the winning source so downstream stages can route completions back.

Parameters:
- DATA_BITS, 96, width of the metadata payload; identical on all inputs and the output.
- N_ID, 4, number of input streams; legal range 1..16.
- ID_BITS, (N_ID>1 ? $clog2(N_ID) : 1), width of the source tag; derived, not overridden.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_meta  in  metaIntf.s [N_ID]  input request streams; each has valid, ready and data[DATA_BITS-1:0].
- m_meta  out  metaIntf.m  merged output stream; valid, ready, data[DATA_BITS-1:0].
- m_id  out  ID_BITS  source index of the beat currently on m_meta; valid whenever m_meta.valid=1.

Behaviour:
- Reset (async assert, sync release): m_meta.valid=0, m_meta.data=0, m_id=0, priority pointer rr_ptr=0, all s_meta[i].ready=0.
- Output stage: a single register (out_valid, out_data, out_id).
- free = !out_valid | m_meta.ready.
- Arbitration is combinational each cycle. Search the requests (s_meta[i].valid) starting at index rr_ptr, ascending with wrap at N_ID-1 to 0. The first valid index is the winner g.
- Grant: if free and any request is present:
  - s_meta[g].ready=1 and all other readies are 0.
  - Next edge: out_data <= s_meta[g].data, out_id <= g, out_valid <= 1, rr_ptr <= (g+1) mod N_ID.
- Readies are never asserted when not free. A valid with no grant stays pending; the source must hold its data stable (AXI-S rules).
- If m_meta.ready=1 and no request is present, out_valid <= 0 and rr_ptr is unchanged.
- If m_meta.ready=0 and out_valid=1, the output register holds data and id stable.
- Latency: 1 cycle from input handshake to m_meta.valid.
- Throughput: 1 beat/cycle when m_meta.ready is held high (pass-through on simultaneous drain and fill).
- Fairness: with all N_ID inputs continuously valid, grants rotate 0,1,...,N_ID-1,0,...; no input waits more than N_ID-1 grants.
- rr_ptr wrap: g=N_ID-1 gives rr_ptr=0.
- N_ID=1: acts as a 1-deep register slice; m_id is constant 0 and rr_ptr is constant 0.
- ready depends combinationally on m_meta.ready. There is no combinational path from any s_meta.valid to m_meta.valid.
- Reset asserted mid-operation: the beat held in the output register is discarded, and the pointer returns to 0.

Optional Feature:
- Macro: META_RR_ARB_STATS_EN.
- When defined:
  - Adds output port stat_cnt [N_ID][31:0], one counter per source.
  - Counter i increments on each accepted input handshake from source i and saturates at 32'hFFFF_FFFF.
  - Adds input port stat_clr (1 bit): a synchronous clear of all counters that takes priority over an increment in the same cycle.
  - All counters reset to 0 on aresetn.
- When undefined: neither port exists and no counter logic is built. Arbitration behaviour is identical in both builds.

Test Plan:
- N_ID=4, only s_meta[2] valid with data 0x...AB, m_meta.ready=1 -> m_meta.valid one cycle later with data 0x...AB, m_id=2; rr_ptr becomes 3.
- All four inputs valid continuously, m_meta.ready=1 for 8 cycles -> m_id sequence 0,1,2,3,0,1,2,3; one output beat per cycle; each input sees ready exactly on its turn.
- Output full and m_meta.ready=0 for 5 cycles with inputs 1 and 3 valid -> all readies 0, m_meta.data/m_id stable. Release ready -> next grant goes to the lowest index at or after rr_ptr.
- Inputs 0 and 3 valid, rr_ptr=3 -> grant 3 then 0 (wrap); rr_ptr goes 3 -> 0 -> 1.
- Assert aresetn=0 asynchronously while m_meta.valid=1 -> m_meta.valid drops to 0 immediately, m_id=0. After release, the first grant follows rr_ptr=0.
- With META_RR_ARB_STATS_EN: 10 grants to source 1 -> stat_cnt[1]=10. Assert stat_clr in the same cycle as a grant to source 1 -> stat_cnt[1]=0. Preload a counter near max -> it saturates at 0xFFFF_FFFF.
